// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with sof framing, a one-entry output register and overrun/resync flags
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     si,
    input  logic                     si_valid,
    input  logic                     sof,
    output logic [WIDTH-1:0]         po,
    output logic                     po_valid,
    input  logic                     po_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     busy,
    output logic                     overrun,
    output logic                     frame_err,
    input  logic                     clr_ovr
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, po_q, po_d, word;
    logic [CW-1:0]    cnt_q, cnt_d, pos;
    logic             pov_q, pov_d, ovr_q, ovr_d, ferr_q, ferr_d, done;
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ferr_d  = 1'b0;
        done    = 1'b0;
        pos     = (LSB_FIRST != 0) ? cnt_q : LAST - cnt_q;
        word    = sr_q;
        word[pos] = si;
        if (si_valid && sof) begin
            ferr_d  = (state_q == SHIFT);
            sr_d    = '0;
            sr_d[(LSB_FIRST != 0) ? 0 : WIDTH - 1] = si;
            cnt_d   = CW'(1);
            state_d = SHIFT;
        end else if (si_valid && state_q == SHIFT) begin
            done    = (cnt_q == LAST);
            sr_d    = done ? '0 : word;
            cnt_d   = done ? '0 : cnt_q + CW'(1);
            state_d = done ? IDLE : SHIFT;
        end
        // a completed word loads if the slot is empty or being drained this edge, otherwise it is dropped
        po_d  = (done && (!pov_q || po_ready)) ? word : po_q;
        pov_d = done | (pov_q & ~po_ready);
        ovr_d = (done & pov_q & ~po_ready) | (ovr_q & ~clr_ovr);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            po_q    <= '0;
            pov_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            po_q    <= po_d;
            pov_q   <= pov_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end
    assign po        = po_q;
    assign po_valid  = pov_q;
    assign bit_cnt   = cnt_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: per-cycle model comparison for a 4-bit LSB-first instance plus directed checks on an 8-bit MSB-first instance
module tb_sipo_deser;
    logic clk = 1'b0;
    logic rst, si, si_valid, sof, po_ready, clr_ovr;
    logic [3:0] a_po;
    logic [1:0] a_cnt;
    logic       a_pov, a_busy, a_ovr, a_ferr;
    logic [7:0] b_po;
    logic [2:0] b_cnt;
    logic       b_pov, b_busy, b_ovr, b_ferr;
    int nchk = 0;
    int nerr = 0;
    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(4), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .sof(sof),
        .po(a_po), .po_valid(a_pov), .po_ready(po_ready), .bit_cnt(a_cnt),
        .busy(a_busy), .overrun(a_ovr), .frame_err(a_ferr), .clr_ovr(clr_ovr)
    );
    sipo_deser #(.WIDTH(8), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .sof(sof),
        .po(b_po), .po_valid(b_pov), .po_ready(po_ready), .bit_cnt(b_cnt),
        .busy(b_busy), .overrun(b_ovr), .frame_err(b_ferr), .clr_ovr(clr_ovr)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // model of the 4-bit LSB-first instance: received bits of the open word kept in a queue
    bit         q[$];
    logic [3:0] m_po, w;
    logic       m_pov, m_ovr, m_ferr, m_done, m_set;
    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_po = '0; m_pov = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        end else begin
            m_done = 1'b0;
            m_ferr = 1'b0;
            if (si_valid && sof) begin
                m_ferr = (q.size() != 0);
                q.delete();
                q.push_back(si);
            end else if (si_valid && q.size() != 0) begin
                q.push_back(si);
                if (q.size() == 4) begin
                    for (int k = 0; k < 4; k++) w[k] = q[k];
                    m_done = 1'b1;
                    q.delete();
                end
            end
            m_set = m_done && m_pov && !po_ready;
            if (m_done && (!m_pov || po_ready)) begin
                m_po  = w;
                m_pov = 1'b1;
            end else if (m_pov && po_ready) m_pov = 1'b0;
            m_ovr = m_set ? 1'b1 : (clr_ovr ? 1'b0 : m_ovr);
        end
        #1;
        chk("po", a_po, m_po);
        chk("po_valid", a_pov, m_pov);
        chk("bit_cnt", a_cnt, q.size());
        chk("busy", a_busy, q.size() != 0);
        chk("overrun", a_ovr, m_ovr);
        chk("frame_err", a_ferr, m_ferr);
    end

    task automatic step(input logic r, input logic v, input logic s, input logic d, input logic rd, input logic c);
        @(negedge clk);
        rst = r; si_valid = v; sof = s; si = d; po_ready = rd; clr_ovr = c;
    endtask

    task automatic idle(input logic rd);
        step(1'b1, 1'b0, 1'b0, 1'b0, rd, 1'b0);
    endtask

    // bit k of the sequence is b[k]; sof on the first bit
    task automatic send(input logic [7:0] b, input int n, input bit gap, input logic rd, input logic rd_last);
        for (int k = 0; k < n; k++) begin
            step(1'b1, 1'b1, k == 0, b[k], (k == n - 1) ? rd_last : rd, 1'b0);
            if (gap) idle(rd);
        end
    endtask

    initial begin
        rst = 1'b0; si_valid = 1'b1; sof = 1'b1; si = 1'b1; po_ready = 1'b0; clr_ovr = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("rst_po", a_po, 0);
        chk("rst_po_valid", a_pov, 0);
        chk("rst_busy", a_busy, 0);
        chk("b_rst_po_valid", b_pov, 0);
        send(8'b1001, 4, 0, 1'b0, 1'b0);
        idle(1'b0);
        chk("first_po", a_po, 4'b1001);
        chk("first_po_valid", a_pov, 1);
        idle(1'b1);
        idle(1'b0);
        chk("consume_po_valid", a_pov, 0);
        send(8'b0000, 4, 1, 1'b1, 1'b1);
        send(8'b1101, 4, 1, 1'b1, 1'b1);
        idle(1'b1);
        chk("b2b_po", a_po, 4'b1101);
        chk("b2b_overrun", a_ovr, 0);
        send(8'b1001, 4, 0, 1'b0, 1'b0);
        send(8'b0110, 4, 0, 1'b0, 1'b0);
        idle(1'b0);
        chk("ovr_po", a_po, 4'b1001);
        chk("ovr_set", a_ovr, 1);
        idle(1'b1);
        idle(1'b0);
        chk("ovr_drain", a_pov, 0);
        chk("ovr_sticky", a_ovr, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("ovr_clear", a_ovr, 0);
        send(8'b1001, 4, 0, 1'b0, 1'b0);
        send(8'b0011, 4, 0, 1'b0, 1'b1);
        idle(1'b0);
        chk("simul_po", a_po, 4'b0011);
        chk("simul_po_valid", a_pov, 1);
        chk("simul_overrun", a_ovr, 0);
        idle(1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("resync_frame_err", a_ferr, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("resync_pulse_end", a_ferr, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("resync_po", a_po, 4'b1010);
        idle(1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        send(8'b1000_1101, 8, 0, 1'b0, 1'b0);
        idle(1'b0);
        chk("msb_po", b_po, 8'b1011_0001);
        chk("msb_po_valid", b_pov, 1);
        idle(1'b1);
        send(8'b101, 3, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("msb_rst_po_valid", b_pov, 0);
        chk("msb_rst_bit_cnt", b_cnt, 0);
        chk("msb_rst_busy", b_busy, 0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(63) != 0, $urandom_range(1) == 1, $urandom_range(5) == 0,
                 $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(15) == 0);
        idle(1'b1);
        idle(1'b1);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in, parallel-out deserializer. It sits directly downstream of the piso shift stage and consumes its serial output.
- Collects WIDTH bits into a word, qualified by a per-bit strobe and a start-of-frame marker.
- Presents each completed word on a one-entry valid/ready output register.
- Flags overrun (word completed while the output is still held) and framing resync (start-of-frame arriving mid-word).

Parameters:
- WIDTH, 4: bits per word; legal range 2..32.
- LSB_FIRST, 1: 1 = first received bit lands in po[0] (matches a right-shifting piso); 0 = first received bit lands in po[WIDTH-1].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low; sampled on rising clk.
- si  input  1  serial data bit.
- si_valid  input  1  si is a valid bit this cycle.
- sof  input  1  start of frame; meaningful only when si_valid=1; marks si as bit 0 of a word.
- po  output  WIDTH  completed parallel word.
- po_valid  output  1  po holds an unconsumed word.
- po_ready  input  1  consumer accepts po when po_valid && po_ready.
- bit_cnt  output  $clog2(WIDTH)  bits collected in the current word.
- busy  output  1  FSM in SHIFT.
- overrun  output  1  sticky; set when a completed word is dropped.
- frame_err  output  1  one-cycle pulse on sof during SHIFT.
- clr_ovr  input  1  clears overrun.

Behaviour:
- Reset (rst=0 at a clk edge) forces: FSM=IDLE, shift reg=0, bit_cnt=0, po=0, po_valid=0, busy=0, overrun=0, frame_err=0. Reset overrides all other inputs. Reset mid-word discards the partial word.
- FSM states: IDLE, SHIFT. A bit is accepted only in a cycle with si_valid=1; cycles with si_valid=0 hold all state (gaps between bits are allowed).
- IDLE:
  - si_valid && sof: capture si as bit 0, bit_cnt=1, go to SHIFT.
  - si_valid && !sof: bit ignored, stay in IDLE.
- SHIFT:
  - si_valid && !sof: capture si at index bit_cnt, bit_cnt+1.
  - si_valid && sof: frame_err=1 for one cycle, discard the partial word, capture si as bit 0, bit_cnt=1, stay in SHIFT.
- Bit placement: with LSB_FIRST=1, received bit k goes to word[k]. With LSB_FIRST=0, it goes to word[WIDTH-1-k].
- Word completion: when bit WIDTH-1 is accepted, the assembled word (including that bit) is offered to the output register. bit_cnt returns to 0 and the FSM returns to IDLE, so the next word needs a new sof.
- Latency: po/po_valid update on the clock edge after the last bit is sampled, i.e. po_valid is high in the cycle following the last-bit cycle.
- Output register load rules, evaluated in the completion cycle:
  - po_valid=0: load po, set po_valid.
  - po_valid=1 && po_ready=1: old word is consumed and the new word loads in the same edge; po_valid stays 1; no overrun.
  - po_valid=1 && po_ready=0: new word dropped, po unchanged, overrun set.
- Output register outside a completion cycle: po_valid && po_ready clears po_valid; po holds its last value.
- po is stable while po_valid=1 && po_ready=0.
- Single-bit frame boundary: sof on the last-bit position of a word is treated as resync (frame_err=1), not as completion.
- overrun is cleared by clr_ovr=1. If clr_ovr and a new overrun event occur in the same cycle, the set wins.
- bit_cnt never exceeds WIDTH-1. Internal count arithmetic is unsigned and wraps to 0 only via completion.

Test Plan:
- Reset: rst=0 for 2 cycles with si_valid=1, sof=1 -> all outputs 0, FSM IDLE. Release, then send bits 1,0,0,1 (sof on the first) -> po=4'b1001, po_valid=1 in the cycle after the 4th bit.
- Back-to-back with gaps: words 4'b0000 then 4'b1101 (bits 1,0,1,1), one si_valid=0 gap between each bit, po_ready=1 -> po=0000 then 1101, one po_valid cycle each, overrun=0.
- Overrun: po_ready=0, send 1001 then 0110 -> po stays 1001, overrun=1. Set po_ready=1 -> po_valid drops. Pulse clr_ovr -> overrun=0.
- Simultaneous consume and load: completion of 0011 in the same cycle as po_ready=1 with 1001 pending -> po=0011, po_valid stays 1, overrun=0.
- Resync: sof after 2 bits (1,1), then bits 0,1,0,1 -> frame_err pulses once, po=4'b1010.
- LSB_FIRST=0, WIDTH=8: bits 1,0,1,1,0,0,0,1 -> po=8'b10110001. rst=0 asserted after 3 bits -> partial word discarded, po_valid stays 0.
